// File: rtl/lowfreq_pkg.sv
// Shared types for the low-frequency measurement scheduler.
// Optional continuous sweeping is enabled with `LFC_AUTO_RESTART_EN.
package lowfreq_pkg;

    localparam int LFC_N_CH  = 4;
    localparam int LFC_CH_W  = 2;
    localparam int LFC_CNT_W = 32;
    localparam int LFC_WIN_W = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_COUNT,
        S_LATCH,
        S_REPORT,
        S_FINISH
    } lfc_state_t;

    typedef struct packed {
        logic [LFC_CH_W-1:0]  ch;
        logic [LFC_CNT_W-1:0] data;
    } lfc_result_t;

endpackage

// File: rtl/lfc_next_channel.sv
// Priority finder: lowest enabled channel index at or above a start index.
module lfc_next_channel #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] mask,
    input  logic [CH_W:0]   from,
    output logic [CH_W-1:0] idx,
    output logic            found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Descending scan so the lowest qualifying index is written last.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                idx   = CH_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lowfreq_meas_scheduler.sv
// Sweeps enabled sensor channels through one shared counter and reports counts.
// Define LFC_AUTO_RESTART_EN for continuous sweeps until abort.
module lowfreq_meas_scheduler
    import lowfreq_pkg::*;
#(
    parameter int N_CH  = LFC_N_CH,
    parameter int CH_W  = LFC_CH_W,
    parameter int CNT_W = LFC_CNT_W,
    parameter int WIN_W = LFC_WIN_W
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             start,
    input  logic             abort,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic [WIN_W-1:0] win_len,
    input  logic [7:0]       settle_len,
    output logic             busy,
    output logic             done,
    output logic [CH_W-1:0]  cnt_sel,
    output logic             cnt_clr,
    output logic             cnt_en,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CH_W-1:0]  res_ch,
    output logic [CNT_W-1:0] res_data
);

    lfc_state_t       state, state_nxt;
    logic [N_CH-1:0]  mask_q;
    logic [WIN_W-1:0] win_q;
    logic [7:0]       settle_q;
    logic [WIN_W-1:0] timer;
    logic [WIN_W-1:0] win_m1;
    logic [N_CH-1:0]  nc_mask;
    logic [CH_W:0]    nc_from;
    logic [CH_W-1:0]  nc_idx;
    logic             nc_found;
    logic             accept;

    assign accept = (state == S_IDLE) && start && !abort;
    // A zero window is measured as a single cycle.
    assign win_m1 = (win_q == '0) ? '0 : win_q - 1'b1;

    always_comb begin
        nc_mask = mask_q;
        nc_from = '0;
        if (state == S_IDLE)
            nc_mask = ch_mask;
        if (state == S_REPORT)
            nc_from = {1'b0, cnt_sel} + (CH_W+1)'(1);
    end

    lfc_next_channel #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_next (
        .mask  (nc_mask),
        .from  (nc_from),
        .idx   (nc_idx),
        .found (nc_found)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:
                if (accept)
                    state_nxt = nc_found ? S_SELECT : S_FINISH;
            S_SELECT:
                state_nxt = (settle_q != 8'd0) ? S_SETTLE : S_COUNT;
            S_SETTLE:
                if (timer == '0)
                    state_nxt = S_COUNT;
            S_COUNT:
                if (timer == '0)
                    state_nxt = S_LATCH;
            S_LATCH:
                state_nxt = S_REPORT;
            S_REPORT:
                if (res_ready)
                    state_nxt = nc_found ? S_SELECT : S_FINISH;
            S_FINISH:
`ifdef LFC_AUTO_RESTART_EN
                state_nxt = nc_found ? S_SELECT : S_IDLE;
`else
                state_nxt = S_IDLE;
`endif
            default:
                state_nxt = S_IDLE;
        endcase
        // Abort wins over every other event, including a result transfer.
        if (abort)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            cnt_sel  <= '0;
            res_ch   <= '0;
            res_data <= '0;
            mask_q   <= '0;
            win_q    <= '0;
            settle_q <= '0;
            timer    <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state == S_FINISH) && !abort;
            if (accept) begin
                mask_q   <= ch_mask;
                win_q    <= win_len;
                settle_q <= settle_len;
            end
            if (state_nxt == S_SELECT)
                cnt_sel <= nc_idx;
            if (state == S_SELECT)
                timer <= (settle_q != 8'd0) ?
                         WIN_W'(settle_q) - 1'b1 : win_m1;
            else if (state == S_SETTLE)
                timer <= (timer == '0) ? win_m1 : timer - 1'b1;
            else if ((state == S_COUNT) && (timer != '0))
                timer <= timer - 1'b1;
            if (state == S_LATCH) begin
                res_data <= cnt_value;
                res_ch   <= cnt_sel;
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign cnt_clr   = (state == S_SELECT);
    assign cnt_en    = (state == S_COUNT);
    assign res_valid = (state == S_REPORT);

endmodule

// File: tb/tb_lowfreq_meas_scheduler.sv
// Scoreboard bench for lowfreq_meas_scheduler with a cycle counter model.
module tb_lowfreq_meas_scheduler;
    import lowfreq_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        start, abort;
    logic [3:0]  ch_mask;
    logic [23:0] win_len;
    logic [7:0]  settle_len;
    logic        busy, done, cnt_clr, cnt_en, res_valid, res_ready;
    logic [1:0]  cnt_sel, res_ch;
    logic [31:0] cnt_value, res_data;

    int checks = 0;
    int passes = 0;
    int done_cnt = 0;
    int en_run = 0;
    int exp_win = 1;
    bit run_check_en = 1'b1;

    lfc_result_t exp_q[$];
    logic [1:0]  sel_q[$];

    lowfreq_meas_scheduler dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .start      (start),
        .abort      (abort),
        .ch_mask    (ch_mask),
        .win_len    (win_len),
        .settle_len (settle_len),
        .busy       (busy),
        .done       (done),
        .cnt_sel    (cnt_sel),
        .cnt_clr    (cnt_clr),
        .cnt_en     (cnt_en),
        .cnt_value  (cnt_value),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_ch     (res_ch),
        .res_data   (res_data)
    );

    always #5 ACLK = ~ACLK;

    // Shared counter: cleared on select, registered one cycle behind cnt_en.
    always @(posedge ACLK) begin
        if (ARESET || cnt_clr)
            cnt_value <= '0;
        else if (cnt_en)
            cnt_value <= cnt_value + 1;
    end

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act == exp)
            passes++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", 1, 0);
                end else begin
                    lfc_result_t e;
                    e = exp_q.pop_front();
                    chk("res_ch", res_ch, e.ch);
                    chk("res_data", res_data, e.data);
                end
            end
            if (cnt_clr) begin
                if (sel_q.size() == 0)
                    chk("sel_unexpected", 1, 0);
                else
                    chk("cnt_sel", cnt_sel, sel_q.pop_front());
            end
            if (done)
                done_cnt++;
            if (cnt_en) begin
                en_run++;
            end else if (en_run != 0) begin
                if (run_check_en)
                    chk("cnt_en_len", en_run, exp_win);
                en_run = 0;
            end
        end
    end

    task automatic push_res(input logic [1:0] ch, input logic [31:0] d);
        lfc_result_t r;
        r.ch   = ch;
        r.data = d;
        exp_q.push_back(r);
    endtask

    task automatic pulse_start(input logic [3:0] m, input logic [23:0] w,
                               input logic [7:0] s);
        @(posedge ACLK); #1;
        ch_mask    = m;
        win_len    = w;
        settle_len = s;
        start      = 1'b1;
        @(posedge ACLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int k = 0; k < budget && done_cnt < n; k++)
            @(negedge ACLK);
        chk("done_wait", done_cnt >= n, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++)
            @(negedge ACLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        ARESET     = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        ch_mask    = '0;
        win_len    = '0;
        settle_len = '0;
        res_ready  = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt_clr", cnt_clr, 0);
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_cnt_sel", cnt_sel, 0);
        chk("rst_res_ch", res_ch, 0);
        chk("rst_res_data", res_data, 0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;

        // Two channels, settle 3, window 100.
        done_cnt = 0;
        exp_win  = 100;
        sel_q.push_back(2'd0);
        sel_q.push_back(2'd2);
        push_res(2'd0, 32'd100);
        push_res(2'd2, 32'd100);
        pulse_start(4'b0101, 24'd100, 8'd3);
        wait_done(1, 400);
        idle_cycles(5);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_res_left", exp_q.size(), 0);
        chk("t1_busy", busy, 0);

        // Empty mask: done two cycles after start, no activity.
        done_cnt = 0;
        pulse_start(4'b0000, 24'd10, 8'd2);
        @(negedge ACLK);
        chk("t2_done_c1", done, 0);
        chk("t2_busy_c1", busy, 1);
        @(negedge ACLK);
        chk("t2_done_c2", done, 1);
        chk("t2_busy_c2", busy, 0);
        idle_cycles(5);
        chk("t2_done_cnt", done_cnt, 1);

        // Backpressure on channel 1.
        done_cnt = 0;
        exp_win  = 5;
        for (int c = 0; c < 4; c++) begin
            sel_q.push_back(2'(c));
            push_res(2'(c), 32'd5);
        end
        pulse_start(4'b1111, 24'd5, 8'd2);
        for (int k = 0; k < 100 && !(res_valid && res_ch == 2'd0); k++)
            @(negedge ACLK);
        chk("t3_ch0_seen", res_valid && res_ch == 2'd0, 1);
        @(posedge ACLK); #1;
        res_ready = 1'b0;
        for (int k = 0; k < 100 && !res_valid; k++)
            @(negedge ACLK);
        for (int k = 0; k < 20; k++) begin
            chk("t3_hold_valid", res_valid, 1);
            chk("t3_hold_ch", res_ch, 1);
            chk("t3_hold_data", res_data, 5);
            chk("t3_no_select", cnt_clr, 0);
            @(negedge ACLK);
        end
        @(posedge ACLK); #1;
        res_ready = 1'b1;
        wait_done(1, 200);
        idle_cycles(3);
        chk("t3_res_left", exp_q.size(), 0);
        chk("t3_sel_left", sel_q.size(), 0);

        // Abort while counting channel 1.
        done_cnt = 0;
        exp_win  = 50;
        sel_q.push_back(2'd0);
        sel_q.push_back(2'd1);
        push_res(2'd0, 32'd50);
        pulse_start(4'b0011, 24'd50, 8'd0);
        for (int k = 0; k < 300 && !(cnt_en && cnt_sel == 2'd1); k++)
            @(negedge ACLK);
        chk("t4_counting_ch1", cnt_en && cnt_sel == 2'd1, 1);
        run_check_en = 1'b0;
        @(posedge ACLK); #1;
        abort = 1'b1;
        @(posedge ACLK); #1;
        abort = 1'b0;
        @(negedge ACLK);
        chk("t4_cnt_en", cnt_en, 0);
        chk("t4_busy", busy, 0);
        chk("t4_res_valid", res_valid, 0);
        idle_cycles(10);
        run_check_en = 1'b1;
        chk("t4_no_done", done_cnt, 0);
        chk("t4_res_left", exp_q.size(), 0);

        // Restart after abort.
        exp_win = 3;
        sel_q.push_back(2'd1);
        push_res(2'd1, 32'd3);
        pulse_start(4'b0010, 24'd3, 8'd1);
        wait_done(1, 100);
        chk("t4b_res_left", exp_q.size(), 0);

        // Zero window and settle; a start while busy is ignored.
        done_cnt = 0;
        exp_win  = 1;
        sel_q.push_back(2'd3);
        push_res(2'd3, 32'd1);
        pulse_start(4'b1000, 24'd0, 8'd0);
        pulse_start(4'b0001, 24'd7, 8'd0);
        wait_done(1, 100);
        idle_cycles(10);
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_res_left", exp_q.size(), 0);
        chk("t5_sel_left", sel_q.size(), 0);

`ifdef LFC_AUTO_RESTART_EN
        // Continuous sweeps of channel 1 until abort.
        done_cnt = 0;
        exp_win  = 4;
        for (int k = 0; k < 4; k++)
            sel_q.push_back(2'd1);
        for (int k = 0; k < 3; k++)
            push_res(2'd1, 32'd4);
        pulse_start(4'b0010, 24'd4, 8'd0);
        wait_done(3, 200);
        chk("t6_busy_between", busy, 1);
        run_check_en = 1'b0;
        @(posedge ACLK); #1;
        abort = 1'b1;
        @(posedge ACLK); #1;
        abort = 1'b0;
        idle_cycles(10);
        run_check_en = 1'b1;
        chk("t6_busy", busy, 0);
        chk("t6_done_cnt", done_cnt, 3);
        chk("t6_res_left", exp_q.size(), 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
